// File: rtl/if_fetch_stage_pkg.sv
// Package: if_fetch_stage_pkg
// Shared constants for the instruction-fetch stage: reset/vector addresses,
// the NOP word injected into IF/ID, next-PC select encodings and a helper
// that forms the sequential PC while preserving the supervisor bit (pc[31]).
package if_fetch_stage_pkg;

  localparam logic [31:0] PC_RESET   = 32'h8000_0000;
  localparam logic [31:0] ILLOP_ADDR = 32'h8000_0004;
  localparam logic [31:0] XADR_ADDR  = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_J   = 2'd2;
  localparam logic [1:0] PCSEL_JR  = 2'd3;

  // PC+4 wraps inside the low 31 bits; supervisor bit is never changed here.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    seq_pc = {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Interface: if_fetch_stage_if
// Bundles every non-clock/reset signal of the fetch stage.
//   master : pipeline side (hazard unit, ID/EX redirect, ROM) - drives
//            stall/pc_sel/targets/flush/irq/exc/rom_data, reads the rest.
//   slave  : the fetch stage itself.
// Handshake: there is no valid/ready pair on the control inputs; they are
// sampled on every rising edge. ifid_valid qualifies ifid_instr/ifid_pc_plus4
// toward ID, and irq_taken is a single-cycle pulse with no acknowledge.
interface if_fetch_stage_if;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [31:0] branch_target;
  logic [25:0] jump_target;
  logic [31:0] jr_target;
  logic        flush;
  logic        irq;
  logic        exc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        irq_taken;

  modport master (
    output stall, pc_sel, branch_target, jump_target, jr_target,
           flush, irq, exc, rom_data,
    input  rom_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, irq_taken
  );

  modport slave (
    input  stall, pc_sel, branch_target, jump_target, jr_target,
           flush, irq, exc, rom_data,
    output rom_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, irq_taken
  );
endinterface

// File: rtl/if_fetch_stage_pc_gen.sv
// Module: if_pc_gen
// Combinational next-PC selection with priority and interrupt masking.
// Ports:
//   pc            in  current PC
//   stall         in  hold request (lowest priority)
//   pc_sel        in  0=seq 1=branch 2=jump 3=jr
//   branch_low    in  branch target bits [30:0]
//   jump_target   in  26-bit instr_index
//   jr_target     in  register target
//   irq, exc      in  interrupt request / undefined-instruction exception
//   next_pc       out PC to load on the next edge
//   redirect      out control transfer this cycle (IF/ID must squash)
//   irq_accept    out interrupt is being taken this cycle
// Option IF_ALIGN_CHECK_EN: a misaligned jr target traps to XADR_ADDR
// instead of having its low two bits cleared.
module if_pc_gen
  import if_fetch_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic [30:0] branch_low,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        irq_accept
);

  logic [31:0] jr_next;

  // Interrupts are masked in supervisor mode; an exception in the same cycle
  // wins and leaves the (level) irq to be re-sampled later.
  assign irq_accept = irq & ~pc[31] & ~exc;
  assign redirect   = exc | irq_accept | (pc_sel != PCSEL_SEQ);

  always_comb begin
`ifdef IF_ALIGN_CHECK_EN
    jr_next = (jr_target[1:0] != 2'b00) ? XADR_ADDR : jr_target;
`else
    jr_next = {jr_target[31:2], 2'b00};
`endif
  end

  always_comb begin
    next_pc = seq_pc(pc);
    if (exc) begin
      next_pc = XADR_ADDR;
    end else if (irq_accept) begin
      next_pc = ILLOP_ADDR;
    end else begin
      case (pc_sel)
        PCSEL_JR: next_pc = jr_next;  // only path allowed to leave kernel mode
        PCSEL_J:  next_pc = {pc[31:28], jump_target, 2'b00};
        PCSEL_BR: next_pc = {pc[31], branch_low};
        default:  next_pc = stall ? pc : seq_pc(pc);
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Module: if_fetch_stage
// Instruction-fetch stage: owns the PC, drives the (combinational) ROM
// address and captures the returned word into the IF/ID register.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    slave modport of if_fetch_stage_if (controls, ROM, IF/ID outputs)
// Option IF_ALIGN_CHECK_EN (see if_pc_gen): trap on misaligned jr target.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  if_fetch_stage_if.slave  bus
);

  logic [31:0] pc_q;
  logic [31:0] next_pc;
  logic        redirect;
  logic        irq_accept;
  logic        squash;
  logic        hold;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;
  logic        irq_taken_q;

  if_pc_gen u_pc_gen (
    .pc          (pc_q),
    .stall       (bus.stall),
    .pc_sel      (bus.pc_sel),
    .branch_low  (bus.branch_target[30:0]),
    .jump_target (bus.jump_target),
    .jr_target   (bus.jr_target),
    .irq         (bus.irq),
    .exc         (bus.exc),
    .next_pc     (next_pc),
    .redirect    (redirect),
    .irq_accept  (irq_accept)
  );

  // Redirects and flushes beat stall for IF/ID; a pure stall freezes it.
  assign squash = redirect | bus.flush;
  assign hold   = bus.stall & ~squash;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= PC_RESET;
      instr_q     <= NOP_INSTR;
      pc_plus4_q  <= 32'h0;
      valid_q     <= 1'b0;
      irq_taken_q <= 1'b0;
    end else begin
      pc_q        <= next_pc;
      irq_taken_q <= irq_accept;
      if (squash) begin
        // PC+4 of the squashed slot is kept so ID can form EPC from it.
        instr_q    <= NOP_INSTR;
        pc_plus4_q <= seq_pc(pc_q);
        valid_q    <= 1'b0;
      end else if (!hold) begin
        instr_q    <= bus.rom_data;
        pc_plus4_q <= seq_pc(pc_q);
        valid_q    <= 1'b1;
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.rom_addr      = pc_q;
  assign bus.ifid_instr    = instr_q;
  assign bus.ifid_pc_plus4 = pc_plus4_q;
  assign bus.ifid_valid    = valid_q;
  assign bus.irq_taken     = irq_taken_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  localparam logic [31:0] T_PC_RESET = 32'h8000_0000;
  localparam logic [31:0] T_ILLOP    = 32'h8000_0004;
  localparam logic [31:0] T_XADR     = 32'h8000_0008;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational ROM: decodes addr[9:2] only.
  logic [31:0] rom_mem [256];
  assign bus.rom_data = rom_mem[bus.rom_addr[9:2]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_valid, m_irq_taken;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc = T_PC_RESET; m_instr = 32'h0; m_pp4 = 32'h0;
      m_valid = 1'b0; m_irq_taken = 1'b0;
    end else begin
      logic        kernel, take_irq, transfer;
      logic [31:0] plus4, target;
      kernel   = m_pc[31];
      take_irq = bus.irq && !kernel && !bus.exc;
      transfer = bus.exc || take_irq || (bus.pc_sel != 2'd0);
      plus4    = {m_pc[31], 31'(m_pc[30:0] + 31'd4)};
      if (bus.exc) target = T_XADR;
      else if (take_irq) target = T_ILLOP;
      else if (bus.pc_sel == 2'd3) begin
`ifdef IF_ALIGN_CHECK_EN
        target = (bus.jr_target % 4 != 0) ? T_XADR : bus.jr_target;
`else
        target = bus.jr_target - (bus.jr_target % 4);
`endif
      end
      else if (bus.pc_sel == 2'd2) target = {m_pc[31:28], bus.jump_target, 2'b00};
      else if (bus.pc_sel == 2'd1) target = {m_pc[31], bus.branch_target[30:0]};
      else if (bus.stall) target = m_pc;
      else target = plus4;

      if (transfer || bus.flush) begin
        m_instr = 32'h0; m_valid = 1'b0; m_pp4 = plus4;
      end else if (!bus.stall) begin
        m_instr = rom_mem[m_pc[9:2]]; m_valid = 1'b1; m_pp4 = plus4;
      end
      m_pc        = target;
      m_irq_taken = take_irq;
    end
  end

  // ---------------- compare process (every negedge) ----------------
  always @(negedge clk) begin
    chk("pc",            bus.pc,                    m_pc);
    chk("rom_addr",      bus.rom_addr,              m_pc);
    chk("ifid_instr",    bus.ifid_instr,            m_instr);
    chk("ifid_pc_plus4", bus.ifid_pc_plus4,         m_pp4);
    chk("ifid_valid",    {31'h0, bus.ifid_valid},   {31'h0, m_valid});
    chk("irq_taken",     {31'h0, bus.irq_taken},    {31'h0, m_irq_taken});
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.stall = 1'b0; bus.pc_sel = 2'd0; bus.flush = 1'b0;
    bus.irq = 1'b0;   bus.exc = 1'b0;
    bus.branch_target = 32'h0; bus.jump_target = 26'h0; bus.jr_target = 32'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    int r;
    idle();
    bus.branch_target = $urandom;
    bus.jump_target   = 26'($urandom);
    bus.jr_target     = $urandom;
    r = $urandom_range(0, 99);
    if (r < 25) bus.stall = 1'b1;
    else if (r < 35) bus.flush = 1'b1;   // flush never combined with stall
    if ($urandom_range(0, 99) < 12) bus.pc_sel = 2'($urandom_range(1, 3));
    if ($urandom_range(0, 99) < 12) bus.irq = 1'b1;
    if ($urandom_range(0, 99) < 5)  bus.exc = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    // reset state
    chk("rst_pc",    bus.pc,            32'h8000_0000);
    chk("rst_instr", bus.ifid_instr,    32'h0);
    chk("rst_pp4",   bus.ifid_pc_plus4, 32'h0);
    chk("rst_valid", {31'h0, bus.ifid_valid}, 32'h0);
    reset = 1'b0;

    // sequential fetch
    cyc();
    chk("seq_pc1",    bus.pc,            32'h8000_0004);
    chk("seq_instr1", bus.ifid_instr,    rom_mem[0]);
    chk("seq_pp4_1",  bus.ifid_pc_plus4, 32'h8000_0004);
    chk("seq_valid1", {31'h0, bus.ifid_valid}, 32'h1);
    cyc();
    chk("seq_pc2",    bus.pc,         32'h8000_0008);
    chk("seq_instr2", bus.ifid_instr, rom_mem[1]);
    repeat (14) cyc();
    chk("seq_pc40",   bus.pc,         32'h8000_0040);

    // stall two cycles at 0x80000040
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("stall_pc",    bus.pc,            32'h8000_0040);
      chk("stall_instr", bus.ifid_instr,    rom_mem[15]);
      chk("stall_pp4",   bus.ifid_pc_plus4, 32'h8000_0040);
    end
    bus.stall = 1'b0;
    cyc();
    chk("resume_pc",    bus.pc,            32'h8000_0044);
    chk("resume_instr", bus.ifid_instr,    rom_mem[16]);
    chk("resume_pp4",   bus.ifid_pc_plus4, 32'h8000_0044);

    // jr to user space
    bus.pc_sel = 2'd3; bus.jr_target = 32'h0000_0100;
    cyc();
    chk("jr_pc",    bus.pc,         32'h0000_0100);
    chk("jr_instr", bus.ifid_instr, 32'h0);
    chk("jr_valid", {31'h0, bus.ifid_valid}, 32'h0);
    idle();
    cyc();
    chk("user_pc",    bus.pc,         32'h0000_0104);
    chk("user_instr", bus.ifid_instr, rom_mem[64]);
    chk("user_valid", {31'h0, bus.ifid_valid}, 32'h1);

    // interrupt in user mode, then masked in kernel mode
    bus.irq = 1'b1;
    cyc();
    chk("irq_pc",    bus.pc,            32'h8000_0004);
    chk("irq_taken", {31'h0, bus.irq_taken}, 32'h1);
    chk("irq_pp4",   bus.ifid_pc_plus4, 32'h0000_0108);
    chk("irq_valid", {31'h0, bus.ifid_valid}, 32'h0);
    cyc();
    chk("irq_mask_pc",    bus.pc, 32'h8000_0008);
    chk("irq_mask_taken", {31'h0, bus.irq_taken}, 32'h0);
    idle();

    // exc + irq + stall together from user mode
    bus.pc_sel = 2'd3; bus.jr_target = 32'h0000_0200;
    cyc();
    chk("jr200_pc", bus.pc, 32'h0000_0200);
    idle();
    bus.exc = 1'b1; bus.irq = 1'b1; bus.stall = 1'b1;
    cyc();
    chk("exc_pc",    bus.pc,         32'h8000_0008);
    chk("exc_taken", {31'h0, bus.irq_taken}, 32'h0);
    chk("exc_instr", bus.ifid_instr, 32'h0);
    chk("exc_valid", {31'h0, bus.ifid_valid}, 32'h0);
    idle();

    // misaligned jr
    bus.pc_sel = 2'd3; bus.jr_target = 32'h0000_0102;
    cyc();
`ifdef IF_ALIGN_CHECK_EN
    chk("jr_misalign_pc", bus.pc, 32'h8000_0008);
`else
    chk("jr_misalign_pc", bus.pc, 32'h0000_0100);
`endif
    chk("jr_misalign_valid", {31'h0, bus.ifid_valid}, 32'h0);
    idle();
    cyc();

    // asynchronous reset mid-cycle
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc",    bus.pc,            32'h8000_0000);
    chk("async_instr", bus.ifid_instr,    32'h0);
    chk("async_pp4",   bus.ifid_pc_plus4, 32'h0);
    chk("async_valid", {31'h0, bus.ifid_valid}, 32'h0);
    chk("async_taken", {31'h0, bus.irq_taken},  32'h0);
    cyc();
    reset = 1'b0;

    // randomized traffic checked by the model
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    idle();
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
